cpri_bram_frame_reader: RTL

Read-side controller for the dual-port frame RAM in the CPRI package TX path. It accepts "bank written" notifications from the write side, issues read addresses to the RAM's B port, and absorbs the fixed RAM read latency in a small skid FIFO. It presents each bank as one framed valid/ready stream with sop/eop, and returns a release pulse per bank so the writer can reuse it.

---
 rtl/cpri_tx_pkg.sv | 27 ++
 rtl/cpri_bram_frame_reader_if.sv | 13 +
 rtl/cpri_sync_fifo.sv | 45 ++++
 rtl/cpri_bram_frame_reader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpri_tx_pkg.sv
// Shared types and derivations for the CPRI TX frame-RAM read path.
package cpri_tx_pkg;

  // Bank tag field is sized for the largest supported bank count; callers slice it.
  localparam int TAG_BANK_W = 8;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [TAG_BANK_W-1:0] bank;
  } tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Skid FIFO must hold every word in flight plus one cycle of pop/credit slack.
  function automatic int skid_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int addr_width(input int frame_len, input int num_banks);
    return $clog2(frame_len * num_banks);
  endfunction

endpackage

// File: rtl/cpri_bram_frame_reader_if.sv
// Framed valid/ready stream carrying one RAM bank per sop..eop packet.
interface cpri_bram_frame_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;

  modport master (output m_data, m_valid, m_sop, m_eop, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, output m_ready);
endinterface

// File: rtl/cpri_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push on full is dropped.
module cpri_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Head entry is never overwritten while occupied, so dout holds steady under stall.
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cpri_bram_frame_reader.sv
// Reads written RAM banks out as sop/eop framed streams and releases each bank once delivered.
module cpri_bram_frame_reader
  import cpri_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FRAME_LEN  = 256,
  parameter  int NUM_BANKS  = 2,
  parameter  int RD_LATENCY = 3,
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int OFF_W      = $clog2(FRAME_LEN),
  localparam int ADDR_WIDTH = addr_width(FRAME_LEN, NUM_BANKS),
  localparam int SKID_DEPTH = skid_depth(RD_LATENCY)
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   frame_rdy,
  input  logic [BANK_W-1:0]      frame_bank,
  output logic                   frame_ack,
  output logic [BANK_W-1:0]      ack_bank,
  output logic                   rden,
  output logic [ADDR_WIDTH-1:0]  rdaddress,
  output logic                   rd_aclr,
  input  logic [DATA_WIDTH-1:0]  q,
  cpri_bram_frame_reader_if.master m,
  output logic                   busy,
  output logic                   overflow
);

  localparam int PQ_CW = $clog2(NUM_BANKS + 1);
  localparam int SK_CW = $clog2(SKID_DEPTH + 1);
  localparam int SK_W  = DATA_WIDTH + $bits(tag_t);

  rd_state_e         state_q;
  logic [OFF_W-1:0]  offset_q;
  logic [BANK_W-1:0] bank_q;

  logic [BANK_W-1:0] pq_head;
  logic [PQ_CW-1:0]  pq_count;
  logic              pq_pop, pq_nonempty, last_word, credit;

  logic [RD_LATENCY:1] vld_pipe_q;
  tag_t [RD_LATENCY:1] tag_pipe_q;
  tag_t                rd_tag, head_tag;
  int                  inflight;

  logic [SK_W-1:0]   sk_dout;
  logic [SK_CW-1:0]  sk_count;
  logic              sk_pop;

  logic              ack_q, ovf_q;
  logic [BANK_W-1:0] ack_bank_q;

  assign rd_aclr = ~aclr_n;

  cpri_sync_fifo #(.WIDTH(BANK_W), .DEPTH(NUM_BANKS)) u_pend_q (
    .clk     (clock),
    .rst_n   (aclr_n),
    .push_i  (frame_rdy),
    .din_i   (frame_bank),
    .pop_i   (pq_pop),
    .dout_o  (pq_head),
    .count_o (pq_count)
  );

  assign pq_nonempty = (pq_count != '0);
  assign last_word   = (offset_q == OFF_W'(FRAME_LEN - 1));

  always_comb begin
    inflight = 0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight += int'(vld_pipe_q[i]);
  end

  assign sk_pop    = m.m_valid && m.m_ready;
  assign credit    = (int'(sk_count) + inflight - int'(sk_pop)) < SKID_DEPTH;
  assign rden      = (state_q == READ) && credit;
  assign rdaddress = {bank_q, offset_q};
  // The next bank is chained straight from the last issue so the stream has no gap.
  assign pq_pop    = pq_nonempty && ((state_q == IDLE) || (rden && last_word));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      offset_q <= '0;
      bank_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (pq_nonempty) begin
          state_q  <= READ;
          offset_q <= '0;
          bank_q   <= pq_head;
        end
        READ: if (rden) begin
          offset_q <= offset_q + 1'b1;
          if (last_word) begin
            if (pq_nonempty) bank_q <= pq_head;
            else             state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_tag      = '0;
    rd_tag.sop  = (offset_q == '0);
    rd_tag.eop  = last_word;
    rd_tag.bank = TAG_BANK_W'(bank_q);
  end

  // Tags ride alongside the RAM pipeline so they meet q at the final stage.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= rden;
      tag_pipe_q[1] <= rd_tag;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  cpri_sync_fifo #(.WIDTH(SK_W), .DEPTH(SKID_DEPTH)) u_skid (
    .clk     (clock),
    .rst_n   (aclr_n),
    .push_i  (vld_pipe_q[RD_LATENCY]),
    .din_i   ({tag_pipe_q[RD_LATENCY], q}),
    .pop_i   (sk_pop),
    .dout_o  (sk_dout),
    .count_o (sk_count)
  );

  assign {head_tag, m.m_data} = sk_dout;
  assign m.m_valid = (sk_count != '0);
  assign m.m_sop   = m.m_valid && head_tag.sop;
  assign m.m_eop   = m.m_valid && head_tag.eop;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ack_q      <= 1'b0;
      ack_bank_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ack_q <= sk_pop && head_tag.eop;
      if (sk_pop && head_tag.eop) ack_bank_q <= head_tag.bank[BANK_W-1:0];
      ovf_q <= frame_rdy && (pq_count == PQ_CW'(NUM_BANKS));
    end
  end

  assign frame_ack = ack_q;
  assign ack_bank  = ack_bank_q;
  assign overflow  = ovf_q;
  assign busy      = pq_nonempty || (state_q == READ) || (inflight != 0) || m.m_valid;

endmodule
